spi_mem_ctrl: RTL and testbench
===============================

Name: spi_mem_ctrl

Overview:
- Command decoder and single-port RAM sitting behind spi_slave: consumes 10-bit rx_data words, keeps the write/read address registers, performs memory writes, and sequences read-backs by driving tx_data/tx_valid back to the slave.
- Command = rx_data[9:8], payload = rx_data[7:0]. 00 = write address, 01 = write data, 10 = read address, 11 = read data (payload is dummy).
- Together with spi_slave it forms the complete SPI-addressable RAM.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; legal range 1..8. Payload bits above ADDR_SIZE are ignored.
- AUTO_INC, 0, when 1 the address post-increments after each data write/read, wrapping MEM_DEPTH-1 -> 0.
- TX_HOLD, 10, number of cycles tx_valid stays high per read; legal range 1..255.

Ports:
- clk, input, 1, rising-edge clock shared with spi_slave.
- rst_n, input, 1, asynchronous, active-low reset.
- rx_data, input, 10, command/payload word from spi_slave.
- rx_valid, input, 1, single-cycle strobe qualifying rx_data.
- tx_data, output, 8, read-back byte to spi_slave.
- tx_valid, output, 1, high while tx_data is offered for shifting out.
- busy, output, 1, high when state != IDLE.
- rd_overrun, output, 1, one-cycle pulse when a read-data command is dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - wr_addr = 0, rd_addr = 0, tx_data = 0, tx_valid = 0, rd_overrun = 0, state = IDLE, hold counter = 0.
  - Memory contents are not reset.
- Commands are sampled on the rising edge of clk when rx_valid = 1. rx_data is ignored when rx_valid = 0.
- Cmd 00: wr_addr <= payload[ADDR_SIZE-1:0]. Accepted in any state.
- Cmd 01: mem[wr_addr] <= payload. If AUTO_INC = 1, wr_addr <= wr_addr + 1, modulo MEM_DEPTH. Accepted in any state.
- Cmd 10: rd_addr <= payload[ADDR_SIZE-1:0]. Accepted in any state; an in-flight read is unaffected.
- Cmd 11:
  - In IDLE: go to READ.
  - In READ or TX: the command is dropped, rd_overrun pulses high for 1 cycle, and state and addresses are unchanged.
- State machine (IDLE, READ, TX):
  - IDLE -> READ on an accepted cmd 11.
  - READ (1 cycle): tx_data <= mem[rd_addr] (synchronous read). If AUTO_INC = 1, rd_addr increments, modulo MEM_DEPTH. Load counter = TX_HOLD. Go to TX.
  - TX: tx_valid = 1. The counter decrements each cycle. When the counter reaches 1, the next state is IDLE and tx_valid drops on the same edge. tx_valid is high for exactly TX_HOLD cycles.
- Latency:
  - tx_valid rises 2 clock edges after the edge that samples cmd 11 (edge n samples, READ at n+1, tx_valid high after edge n+2).
  - tx_data is stable from the rising edge of tx_valid and holds its value after tx_valid falls.
- Read/write collision: a cmd 01 to address A sampled on the same edge that the READ state reads A returns the OLD data (read-before-write). A write accepted before READ is visible.
- Back-to-back commands: one command per cycle is supported. A cmd 01 immediately after cmd 00 uses the new wr_addr.
- Wrap: with AUTO_INC = 1, an address of MEM_DEPTH-1 increments to 0. With AUTO_INC = 0, addresses never change except via cmds 00/10.
- Reset mid-operation: tx_valid and busy drop asynchronously and the state returns to IDLE. Memory writes already completed persist.
- busy = 1 in READ and TX, 0 in IDLE.

Test Plan:
- Write/read basic:
  - Stimulus: rx 0x050 (wr_addr = 0x50), 0x190 (mem[0x50] = 0x90), 0x250 (rd_addr = 0x50), 0x3FF.
  - Required: tx_valid rises 2 edges after 0x3FF, tx_data = 0x90, tx_valid high for exactly 10 cycles, busy high for 11.
- Reset behaviour:
  - Stimulus: assert rst_n = 0 mid-TX.
  - Required: tx_valid, busy = 0 immediately, tx_data = 0. A subsequent 0x3FF reads mem[0] (rd_addr reset).
- Overrun:
  - Stimulus: issue 0x3FF, then a second 0x3FF during TX.
  - Required: rd_overrun pulses 1 cycle, tx_valid count is still 10, tx_data is unchanged.
- AUTO_INC = 1 wrap:
  - Stimulus: 0x0FF, then 0x1AA, 0x1BB.
  - Required: mem[0xFF] = 0xAA, mem[0x00] = 0xBB.
  - Stimulus: 0x2FF, 0x3xx twice.
  - Required: tx_data 0xAA then 0xBB.
- Collision:
  - Stimulus: mem[0x10] = 0x11, rd_addr = 0x10, wr_addr = 0x10; send 0x3FF, then 0x122 on the next cycle.
  - Required: tx_data = 0x11; a later read of 0x10 returns 0x22.
- Address change during TX:
  - Stimulus: send 0x2AB while tx_valid = 1.
  - Required: current tx_data holds; the next read uses 0xAB.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// Command decoder and 8-bit single-port RAM behind spi_slave.
// Decodes 10-bit rx words, performs writes, and sequences read-backs onto tx_data/tx_valid.
module spi_mem_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0,
  parameter int TX_HOLD   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       rd_overrun
);

  typedef enum logic [1:0] {IDLE, READ, TX} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [9:0]           cmd_p0;
  logic                 vld_p0;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [7:0]           hold_cnt;
  logic [7:0]           mem [MEM_DEPTH];

  logic [1:0]           op;
  logic [ADDR_SIZE-1:0] pay_addr;
  logic [7:0]           pay;
  logic                 rd_req;

  function automatic logic [ADDR_SIZE-1:0] addr_next(input logic [ADDR_SIZE-1:0] a);
    return (AUTO_INC != 0) ? ADDR_SIZE'(a + 1'b1) : a;
  endfunction

  assign op       = cmd_p0[9:8];
  assign pay_addr = cmd_p0[ADDR_SIZE-1:0];
  assign pay      = cmd_p0[7:0];
  assign rd_req   = vld_p0 && (op == 2'b11);
  assign tx_valid = (state == TX);
  assign busy     = (state != IDLE);

  // p0: sample the incoming command word
  always_ff @(posedge clk) begin
    cmd_p0 <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= rx_valid;
  end

  // p1: decode, memory write and read sequencing
  always_ff @(posedge clk) begin
    if (vld_p0 && (op == 2'b01)) mem[wr_addr] <= pay;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = READ;
      READ:    state_nxt = TX;
      TX:      if (hold_cnt == 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_data    <= 8'h00;
      hold_cnt   <= 8'h00;
      rd_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_overrun <= rd_req && (state != IDLE);

      if (vld_p0 && (op == 2'b00))      wr_addr <= pay_addr;
      else if (vld_p0 && (op == 2'b01)) wr_addr <= addr_next(wr_addr);

      // A new read address wins over the post-increment of the read in flight
      if (vld_p0 && (op == 2'b10)) rd_addr <= pay_addr;
      else if (state == READ)      rd_addr <= addr_next(rd_addr);

      if (state == READ) begin
        tx_data  <= mem[rd_addr];
        hold_cnt <= 8'(TX_HOLD);
      end else if (state == TX) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: one instance with AUTO_INC=0, one with AUTO_INC=1.
module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data0 = '0, rx_data1 = '0;
  logic       rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1, busy0, busy1, ovr0, ovr1;

  int n_tests = 0;
  int n_fail  = 0;
  int v0 = 0, b0 = 0, o0 = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0), .TX_HOLD(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .busy(busy0), .rd_overrun(ovr0)
  );

  spi_mem_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1), .TX_HOLD(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .busy(busy1), .rd_overrun(ovr1)
  );

  always @(negedge clk) begin
    if (tx_valid0) v0++;
    if (busy0)     b0++;
    if (ovr0)      o0++;
  end

  task automatic send(input int which, input logic [9:0] w);
    @(negedge clk);
    if (which == 0) begin rx_data0 = w; rx_valid0 = 1'b1; end
    else            begin rx_data1 = w; rx_valid1 = 1'b1; end
    @(negedge clk);
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int guard = 0;
    repeat (2) @(negedge clk);
    while (((which == 0) ? busy0 : busy1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 40) begin
      n_fail++;
      $display("FAIL wait_idle dut%0d: busy still 1 after %0d cycles, required 0", which, guard);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests += 4;
    if (tx_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid0); end
    if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data0); end
    if (ovr0 !== 1'b0)      begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ovr0); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send(0, 10'h050);
    send(0, 10'h190);
    send(0, 10'h250);
    v0 = 0; b0 = 0; o0 = 0;
    send(0, 10'h3FF);
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_edge_n: got %b want 0", busy0); end
    @(negedge clk);
    n_tests += 2;
    if (busy0 !== 1'b1)     begin n_fail++; $display("FAIL basic_busy_edge_n1: got %b want 1", busy0); end
    if (tx_valid0 !== 1'b0) begin n_fail++; $display("FAIL basic_tx_valid_edge_n1: got %b want 0", tx_valid0); end
    @(negedge clk);
    n_tests += 2;
    if (tx_valid0 !== 1'b1) begin n_fail++; $display("FAIL basic_tx_valid_edge_n2: got %b want 1", tx_valid0); end
    if (tx_data0 !== 8'h90) begin n_fail++; $display("FAIL basic_tx_data: got %h want 90", tx_data0); end
    wait_idle(0);
    n_tests += 3;
    if (v0 !== 10) begin n_fail++; $display("FAIL basic_tx_valid_len: got %0d want 10", v0); end
    if (b0 !== 11) begin n_fail++; $display("FAIL basic_busy_len: got %0d want 11", b0); end
    if (tx_data0 !== 8'h90) begin n_fail++; $display("FAIL basic_tx_data_hold: got %h want 90", tx_data0); end
  endtask

  task automatic test_reset_mid();
    send(0, 10'h000);
    send(0, 10'h15A);
    send(0, 10'h3FF);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (tx_valid0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_valid: got %b want 0", tx_valid0); end
    if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data0); end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 10'h3FF);
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'h5A) begin n_fail++; $display("FAIL rstmid_rd_addr0: got %h want 5A", tx_data0); end
    send(0, 10'h1E1);
    send(0, 10'h3FF);
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'hE1) begin n_fail++; $display("FAIL rstmid_wr_addr0: got %h want E1", tx_data0); end
  endtask

  task automatic test_overrun();
    v0 = 0; b0 = 0; o0 = 0;
    send(0, 10'h3FF);
    repeat (3) @(negedge clk);
    send(0, 10'h3FF);
    n_tests++;
    if (tx_data0 !== 8'hE1) begin n_fail++; $display("FAIL ovr_tx_data_mid: got %h want E1", tx_data0); end
    wait_idle(0);
    repeat (3) @(negedge clk);
    n_tests += 4;
    if (o0 !== 1)  begin n_fail++; $display("FAIL ovr_pulse_len: got %0d want 1", o0); end
    if (v0 !== 10) begin n_fail++; $display("FAIL ovr_tx_valid_len: got %0d want 10", v0); end
    if (tx_data0 !== 8'hE1) begin n_fail++; $display("FAIL ovr_tx_data: got %h want E1", tx_data0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ovr_no_second_read: busy %b want 0", busy0); end
  endtask

  task automatic test_collision();
    send(0, 10'h010);
    send(0, 10'h111);
    send(0, 10'h210);
    send(0, 10'h010);
    @(negedge clk);
    rx_data0 = 10'h3FF; rx_valid0 = 1'b1;
    @(negedge clk);
    rx_data0 = 10'h122;
    @(negedge clk);
    rx_valid0 = 1'b0;
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'h11) begin n_fail++; $display("FAIL collision_old: got %h want 11", tx_data0); end
    send(0, 10'h3FF);
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'h22) begin n_fail++; $display("FAIL collision_new: got %h want 22", tx_data0); end
  endtask

  task automatic test_addr_change();
    send(0, 10'h0AB);
    send(0, 10'h177);
    send(0, 10'h3FF);
    repeat (3) @(negedge clk);
    send(0, 10'h2AB);
    n_tests += 2;
    if (tx_valid0 !== 1'b1) begin n_fail++; $display("FAIL addrchg_tx_valid: got %b want 1", tx_valid0); end
    if (tx_data0 !== 8'h22) begin n_fail++; $display("FAIL addrchg_hold: got %h want 22", tx_data0); end
    wait_idle(0);
    send(0, 10'h3FF);
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'h77) begin n_fail++; $display("FAIL addrchg_next: got %h want 77", tx_data0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rx_valid0 = 1'b1;
    rx_data0 = 10'h033; @(negedge clk);
    rx_data0 = 10'h1C3; @(negedge clk);
    rx_data0 = 10'h233; @(negedge clk);
    rx_data0 = 10'h3FF; @(negedge clk);
    rx_valid0 = 1'b0;
    wait_idle(0);
    n_tests++;
    if (tx_data0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_data: got %h want C3", tx_data0); end
  endtask

  task automatic test_auto_inc();
    send(1, 10'h0FF);
    send(1, 10'h1AA);
    send(1, 10'h1BB);
    send(1, 10'h1CC);
    send(1, 10'h2FF);
    send(1, 10'h300);
    wait_idle(1);
    n_tests++;
    if (tx_data1 !== 8'hAA) begin n_fail++; $display("FAIL autoinc_ff: got %h want AA", tx_data1); end
    send(1, 10'h355);
    wait_idle(1);
    n_tests++;
    if (tx_data1 !== 8'hBB) begin n_fail++; $display("FAIL autoinc_wrap00: got %h want BB", tx_data1); end
    send(1, 10'h3A5);
    wait_idle(1);
    n_tests++;
    if (tx_data1 !== 8'hCC) begin n_fail++; $display("FAIL autoinc_01: got %h want CC", tx_data1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_overrun();
    test_collision();
    test_addr_change();
    test_back_to_back();
    test_auto_inc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
